// File: rtl/idu_pkg.sv
// Shared decode definitions for the IDU stage: opcodes, ALU op codes and the decoded bundle.
package idu_pkg;

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    localparam logic [6:0] F7Base   = 7'b0000000;
    localparam logic [6:0] F7Alt    = 7'b0100000;
    localparam logic [6:0] F7MulDiv = 7'b0000001;

    localparam int unsigned AluOpW = 5;

    typedef enum logic [AluOpW-1:0] {
        AluAdd, AluSub, AluSll, AluCmp, AluEq, AluXor, AluSrl, AluSra, AluOr, AluAnd,
        AluMul, AluMulh, AluMulhsu, AluMulhu, AluDiv, AluDivu, AluRem, AluRemu
    } alu_op_e;

    typedef enum logic [1:0] {
        Src1Reg  = 2'd0,
        Src1Pc   = 2'd1,
        Src1Zero = 2'd2
    } src1_sel_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        alu_op_e     alu_op;
        src1_sel_e   src1_sel;
        logic        src2_sel;
        logic        rd_wen;
        logic        mem_wen;
        logic        mem_ren;
        logic        jump;
        logic        branch;
        logic [2:0]  mem_size;
        logic        cmp_unsigned;
        logic        cmp_invert;
        logic        ecall;
        logic        ebreak;
        logic        illegal;
    } decode_t;

    localparam int unsigned DecodeW = $bits(decode_t);

    // Shared by OP and OP-IMM; alt selects SUB/SRA over ADD/SRL.
    function automatic alu_op_e base_alu_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        unique case (f3)
            3'b000:         op = alt ? AluSub : AluAdd;
            3'b001:         op = AluSll;
            3'b010, 3'b011: op = AluCmp;
            3'b100:         op = AluXor;
            3'b101:         op = alt ? AluSra : AluSrl;
            3'b110:         op = AluOr;
            default:        op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/idu_decode_comb.sv
// Purely combinational RV32I(+M) instruction to decoded-bundle translation.
module idu_decode_comb
    import idu_pkg::*;
#(
    parameter int unsigned EN_M = 1
) (
    input  logic [31:0] i_inst,
    output decode_t     o_dec
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
    decode_t     w_dec;

    assign w_opcode = i_inst[6:0];
    assign w_f3     = i_inst[14:12];
    assign w_f7     = i_inst[31:25];

    assign w_imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b  = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u  = {i_inst[31:12], 12'b0};
    assign w_imm_j  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21],
                       1'b0};
    assign w_imm_sh = {27'b0, i_inst[24:20]};

    always_comb begin
        w_dec          = '0;
        w_dec.rd       = i_inst[11:7];
        w_dec.rs1      = i_inst[19:15];
        w_dec.rs2      = i_inst[24:20];
        w_dec.alu_op   = AluAdd;
        w_dec.src1_sel = Src1Reg;

        case (w_opcode)
            OpcLoad: begin
                w_dec.imm      = w_imm_i;
                w_dec.mem_ren  = 1'b1;
                w_dec.rd_wen   = 1'b1;
                w_dec.mem_size = w_f3;
                if (w_f3 == 3'b011 || w_f3[2:1] == 2'b11) w_dec.illegal = 1'b1;
            end
            OpcStore: begin
                w_dec.imm      = w_imm_s;
                w_dec.mem_wen  = 1'b1;
                w_dec.mem_size = w_f3;
                if (w_f3 > 3'b010) w_dec.illegal = 1'b1;
            end
            OpcOpImm: begin
                w_dec.rd_wen       = 1'b1;
                w_dec.imm          = w_imm_i;
                w_dec.cmp_unsigned = (w_f3[2:1] == 2'b01) && w_f3[0];
                w_dec.alu_op       = base_alu_op(w_f3, (w_f3 == 3'b101) && w_f7[5]);
                if (w_f3 == 3'b001) begin
                    w_dec.imm = w_imm_sh;
                    if (w_f7 != F7Base) w_dec.illegal = 1'b1;
                end else if (w_f3 == 3'b101) begin
                    w_dec.imm = w_imm_sh;
                    if (w_f7 != F7Base && w_f7 != F7Alt) w_dec.illegal = 1'b1;
                end
            end
            OpcOp: begin
                w_dec.rd_wen   = 1'b1;
                w_dec.src2_sel = 1'b1;
                if (w_f7 == F7MulDiv) begin
                    if (EN_M != 0) begin
                        unique case (w_f3)
                            3'b000:  w_dec.alu_op = AluMul;
                            3'b001:  w_dec.alu_op = AluMulh;
                            3'b010:  w_dec.alu_op = AluMulhsu;
                            3'b011:  w_dec.alu_op = AluMulhu;
                            3'b100:  w_dec.alu_op = AluDiv;
                            3'b101:  w_dec.alu_op = AluDivu;
                            3'b110:  w_dec.alu_op = AluRem;
                            default: w_dec.alu_op = AluRemu;
                        endcase
                    end else begin
                        w_dec.illegal = 1'b1;
                    end
                end else begin
                    w_dec.alu_op       = base_alu_op(w_f3, w_f7[5]);
                    w_dec.cmp_unsigned = (w_f3[2:1] == 2'b01) && w_f3[0];
                    // Only ADD/SUB and SRL/SRA have an alternate funct7 form.
                    if (!(w_f7 == F7Base ||
                          (w_f7 == F7Alt && (w_f3 == 3'b000 || w_f3 == 3'b101)))) begin
                        w_dec.illegal = 1'b1;
                    end
                end
            end
            OpcLui: begin
                w_dec.imm      = w_imm_u;
                w_dec.src1_sel = Src1Zero;
                w_dec.rd_wen   = 1'b1;
            end
            OpcAuipc: begin
                w_dec.imm      = w_imm_u;
                w_dec.src1_sel = Src1Pc;
                w_dec.rd_wen   = 1'b1;
            end
            OpcJal: begin
                w_dec.imm      = w_imm_j;
                w_dec.src1_sel = Src1Pc;
                w_dec.jump     = 1'b1;
                w_dec.rd_wen   = 1'b1;
            end
            OpcJalr: begin
                w_dec.imm    = w_imm_i;
                w_dec.jump   = 1'b1;
                w_dec.rd_wen = 1'b1;
            end
            OpcBranch: begin
                w_dec.imm          = w_imm_b;
                w_dec.src2_sel     = 1'b1;
                w_dec.branch       = 1'b1;
                w_dec.alu_op       = w_f3[2] ? AluCmp : AluEq;
                w_dec.cmp_unsigned = w_f3[2] && w_f3[1];
                w_dec.cmp_invert   = w_f3[0];
                if (w_f3[2:1] == 2'b01) w_dec.illegal = 1'b1;
            end
            OpcSystem: begin
                if (i_inst == 32'h0000_0073) begin
                    w_dec.ecall = 1'b1;
                end else if (i_inst == 32'h0010_0073) begin
                    w_dec.ebreak = 1'b1;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            default: w_dec.illegal = 1'b1;
        endcase

        if (i_inst[1:0] != 2'b11) w_dec.illegal = 1'b1;

        if (w_dec.illegal || w_dec.ecall || w_dec.ebreak || w_dec.rd == 5'd0) begin
            w_dec.rd_wen = 1'b0;
        end
        if (w_dec.illegal) begin
            w_dec.mem_wen = 1'b0;
            w_dec.mem_ren = 1'b0;
            w_dec.jump    = 1'b0;
            w_dec.branch  = 1'b0;
        end
    end

    assign o_dec = w_dec;

endmodule

// File: rtl/idu_decode_stage.sv
// Registered decode stage: valid/ready handshake with main + skid entries, flush and reset.
module idu_decode_stage
    import idu_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned EN_M     = 1,
    parameter int unsigned ALU_OP_W = 5,
    parameter int unsigned SKID     = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [31:0]         i_in_inst,
    input  logic [XLEN-1:0]     i_in_pc,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [XLEN-1:0]     o_out_pc,
    output logic [4:0]          o_out_rd,
    output logic [4:0]          o_out_rs1,
    output logic [4:0]          o_out_rs2,
    output logic [XLEN-1:0]     o_out_imm,
    output logic [ALU_OP_W-1:0] o_out_alu_op,
    output logic [1:0]          o_out_src1_sel,
    output logic                o_out_src2_sel,
    output logic                o_out_rd_wen,
    output logic                o_out_mem_wen,
    output logic                o_out_mem_ren,
    output logic                o_out_jump,
    output logic                o_out_branch,
    output logic [2:0]          o_out_mem_size,
    output logic                o_out_cmp_unsigned,
    output logic                o_out_cmp_invert,
    output logic                o_out_ecall,
    output logic                o_out_ebreak,
    output logic                o_out_illegal
);

    decode_t         w_dec;
    decode_t         r_main, r_skid;
    logic [XLEN-1:0] r_main_pc, r_skid_pc;
    logic            r_main_valid, r_skid_valid;
    logic            w_accept, w_xfer;

    idu_decode_comb #(
        .EN_M (EN_M)
    ) u_decode (
        .i_inst (i_in_inst),
        .o_dec  (w_dec)
    );

    // With a skid entry, in_ready depends only on state, breaking the out_ready path.
    assign o_in_ready = (SKID != 0) ? !r_skid_valid : (!r_main_valid || i_out_ready);
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_xfer     = r_main_valid && i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
            r_main_pc    <= '0;
            r_skid_pc    <= '0;
        end else if (i_flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_xfer) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_pc    <= r_skid_pc;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main    <= w_dec;
                r_main_pc <= i_in_pc;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Reachable with main occupied only when SKID=1 (otherwise accept implies transfer).
            if (r_main_valid) begin
                r_skid       <= w_dec;
                r_skid_pc    <= i_in_pc;
                r_skid_valid <= 1'b1;
            end else begin
                r_main       <= w_dec;
                r_main_pc    <= i_in_pc;
                r_main_valid <= 1'b1;
            end
        end
    end

    assign o_out_valid        = r_main_valid;
    assign o_out_pc           = r_main_pc;
    assign o_out_rd           = r_main.rd;
    assign o_out_rs1          = r_main.rs1;
    assign o_out_rs2          = r_main.rs2;
    assign o_out_imm          = XLEN'($signed(r_main.imm));
    assign o_out_alu_op       = ALU_OP_W'(r_main.alu_op);
    assign o_out_src1_sel     = r_main.src1_sel;
    assign o_out_src2_sel     = r_main.src2_sel;
    assign o_out_rd_wen       = r_main.rd_wen;
    assign o_out_mem_wen      = r_main.mem_wen;
    assign o_out_mem_ren      = r_main.mem_ren;
    assign o_out_jump         = r_main.jump;
    assign o_out_branch       = r_main.branch;
    assign o_out_mem_size     = r_main.mem_size;
    assign o_out_cmp_unsigned = r_main.cmp_unsigned;
    assign o_out_cmp_invert   = r_main.cmp_invert;
    assign o_out_ecall        = r_main.ecall;
    assign o_out_ebreak       = r_main.ebreak;
    assign o_out_illegal      = r_main.illegal;

endmodule

// File: tb/tb_idu_decode_stage.sv
// Directed-vector bench for idu_decode_stage; a second instance runs with the M extension off.
module tb_idu_decode_stage;

    localparam logic [4:0] A_ADD = 5'd0;
    localparam logic [4:0] A_SUB = 5'd1;
    localparam logic [4:0] A_EQ  = 5'd4;
    localparam logic [4:0] A_SRA = 5'd7;
    localparam logic [4:0] A_MUL = 5'd10;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;

    logic        in_ready, out_valid, src2_sel, rd_wen, mem_wen, mem_ren, jump, branch;
    logic        cmp_unsigned, cmp_invert, ecall, ebreak, illegal;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2, alu_op;
    logic [1:0]  src1_sel;
    logic [2:0]  mem_size;

    logic        m0_in_ready, m0_out_valid, m0_src2_sel, m0_rd_wen, m0_mem_wen, m0_mem_ren;
    logic        m0_jump, m0_branch, m0_cmp_unsigned, m0_cmp_invert, m0_ecall, m0_ebreak;
    logic        m0_illegal;
    logic [31:0] m0_out_pc, m0_out_imm;
    logic [4:0]  m0_out_rd, m0_out_rs1, m0_out_rs2, m0_alu_op;
    logic [1:0]  m0_src1_sel;
    logic [2:0]  m0_mem_size;

    int n_cmp;
    int n_err;

    always #5 clk = ~clk;

    idu_decode_stage #(.XLEN(32), .EN_M(1), .ALU_OP_W(5), .SKID(1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_inst(in_inst), .i_in_pc(in_pc), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_pc(out_pc), .o_out_rd(out_rd), .o_out_rs1(out_rs1), .o_out_rs2(out_rs2),
        .o_out_imm(out_imm), .o_out_alu_op(alu_op), .o_out_src1_sel(src1_sel),
        .o_out_src2_sel(src2_sel), .o_out_rd_wen(rd_wen), .o_out_mem_wen(mem_wen),
        .o_out_mem_ren(mem_ren), .o_out_jump(jump), .o_out_branch(branch),
        .o_out_mem_size(mem_size), .o_out_cmp_unsigned(cmp_unsigned),
        .o_out_cmp_invert(cmp_invert), .o_out_ecall(ecall), .o_out_ebreak(ebreak),
        .o_out_illegal(illegal)
    );

    idu_decode_stage #(.XLEN(32), .EN_M(0), .ALU_OP_W(5), .SKID(1)) u_dut_nom (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(m0_in_ready), .i_in_inst(in_inst), .i_in_pc(in_pc),
        .o_out_valid(m0_out_valid), .i_out_ready(out_ready), .o_out_pc(m0_out_pc),
        .o_out_rd(m0_out_rd), .o_out_rs1(m0_out_rs1), .o_out_rs2(m0_out_rs2),
        .o_out_imm(m0_out_imm), .o_out_alu_op(m0_alu_op), .o_out_src1_sel(m0_src1_sel),
        .o_out_src2_sel(m0_src2_sel), .o_out_rd_wen(m0_rd_wen), .o_out_mem_wen(m0_mem_wen),
        .o_out_mem_ren(m0_mem_ren), .o_out_jump(m0_jump), .o_out_branch(m0_branch),
        .o_out_mem_size(m0_mem_size), .o_out_cmp_unsigned(m0_cmp_unsigned),
        .o_out_cmp_invert(m0_cmp_invert), .o_out_ecall(m0_ecall), .o_out_ebreak(m0_ebreak),
        .o_out_illegal(m0_illegal)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        step();
    endtask

    // {rd_wen, mem_wen, mem_ren, jump, branch, ecall, ebreak, illegal}
    function automatic logic [7:0] ctrl();
        return {rd_wen, mem_wen, mem_ren, jump, branch, ecall, ebreak, illegal};
    endfunction

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        step();
        step();
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_imm", out_imm, 0);
        check_eq("rst_pc", out_pc, 0);
        check_eq("rst_ctrl", ctrl(), 0);
        check_eq("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // Back-to-back stream with out_ready high: one bundle per cycle.
        push(32'h0050_0093, 32'h100);                    // addi x1,x0,5
        check_eq("addi_valid", out_valid, 1);
        check_eq("addi_alu", alu_op, A_ADD);
        check_eq("addi_imm", out_imm, 5);
        check_eq("addi_rd", out_rd, 1);
        check_eq("addi_ctrl", ctrl(), 8'b1000_0000);
        check_eq("addi_src2", src2_sel, 0);
        check_eq("addi_pc", out_pc, 32'h100);
        check_eq("addi_nom", {m0_out_valid, m0_alu_op, m0_out_imm, m0_out_rd, m0_out_rs1,
                              m0_src1_sel, m0_src2_sel, m0_mem_size, m0_cmp_unsigned,
                              m0_cmp_invert, m0_rd_wen, m0_in_ready, m0_out_pc},
                 {1'b1, A_ADD, 32'd5, 5'd1, 5'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1,
                  1'b1, 32'h100});
        push(32'h4020_81B3, 32'h104);                    // sub x3,x1,x2
        check_eq("sub_alu", alu_op, A_SUB);
        check_eq("sub_src2", src2_sel, 1);
        check_eq("sub_regs", {out_rd, out_rs1, out_rs2}, {5'd3, 5'd1, 5'd2});
        push(32'h4030_D213, 32'h108);                    // srai x4,x1,3
        check_eq("srai_alu", alu_op, A_SRA);
        check_eq("srai_imm", out_imm, 3);
        check_eq("srai_src2", src2_sel, 0);
        push(32'h0020_9463, 32'h10C);                    // bne x1,x2,+8
        check_eq("bne_alu", alu_op, A_EQ);
        check_eq("bne_inv", {cmp_invert, cmp_unsigned}, 2'b10);
        check_eq("bne_imm", out_imm, 8);
        check_eq("bne_ctrl", ctrl(), 8'b0000_1000);
        check_eq("bne_src2", src2_sel, 1);
        push(32'h0273_02B3, 32'h110);                    // mul x5,x6,x7
        check_eq("mul_alu", alu_op, A_MUL);
        check_eq("mul_ctrl", ctrl(), 8'b1000_0000);
        check_eq("mul_nom_valid", m0_out_valid, 1);
        check_eq("mul_nom_ctrl", {m0_rd_wen, m0_mem_wen, m0_mem_ren, m0_jump, m0_branch,
                                  m0_ecall, m0_ebreak, m0_illegal}, 8'b0000_0001);
        push(32'h0000_0013, 32'h114);                    // nop writes x0
        check_eq("nop_ctrl", ctrl(), 0);
        push(32'h1234_52B7, 32'h118);                    // lui x5,0x12345
        check_eq("lui_imm", out_imm, 32'h1234_5000);
        check_eq("lui_src1", src1_sel, 2);
        push(32'hFFC0_A303, 32'h11C);                    // lw x6,-4(x1)
        check_eq("lw_imm", out_imm, 32'hFFFF_FFFC);
        check_eq("lw_ctrl", ctrl(), 8'b1010_0000);
        check_eq("lw_size", mem_size, 3'b010);
        push(32'h0000_B303, 32'h120);                    // load funct3=011
        check_eq("ld_ctrl", ctrl(), 8'b0000_0001);
        push(32'h0000_0001, 32'h124);                    // inst[1:0] != 11
        check_eq("c16_ill", illegal, 1);
        push(32'h0000_0073, 32'h128);                    // ecall
        check_eq("ecall_ctrl", ctrl(), 8'b0000_0100);
        push(32'h0010_0073, 32'h12C);                    // ebreak
        check_eq("ebreak_ctrl", ctrl(), 8'b0000_0010);
        push(32'h0020_A423, 32'h130);                    // sw x2,8(x1)
        check_eq("sw_imm", out_imm, 8);
        check_eq("sw_ctrl", ctrl(), 8'b0100_0000);
        push(32'h0100_00EF, 32'h134);                    // jal x1,+16
        check_eq("jal_imm", out_imm, 16);
        check_eq("jal_src1", src1_sel, 1);
        check_eq("jal_ctrl", ctrl(), 8'b1001_0000);
        in_valid = 1'b0;
        step();
        check_eq("drain_valid", out_valid, 0);

        // Backpressure: second push lands in skid and drops in_ready.
        out_ready = 1'b0;
        push(32'h0050_0093, 32'h200);
        check_eq("bp_ready1", in_ready, 1);
        push(32'h0060_0113, 32'h204);
        check_eq("bp_ready2", in_ready, 0);
        push(32'h0070_0193, 32'h208);                    // refused while full
        check_eq("bp_hold_imm", out_imm, 5);
        check_eq("bp_hold_pc", out_pc, 32'h200);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq("bp_second_imm", out_imm, 6);
        check_eq("bp_second_pc", out_pc, 32'h204);
        check_eq("bp_ready3", in_ready, 1);
        step();
        check_eq("bp_empty", out_valid, 0);

        // Flush with both entries full and a pending instruction.
        out_ready = 1'b0;
        push(32'h0050_0093, 32'h300);
        push(32'h0060_0113, 32'h304);
        in_valid = 1'b1;
        in_inst  = 32'h0070_0193;
        flush    = 1'b1;
        step();
        check_eq("fl_valid", out_valid, 0);
        check_eq("fl_ready", in_ready, 1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq("fl_gone", out_valid, 0);
        // Flush beats a same-cycle accept.
        in_valid = 1'b1;
        in_pc    = 32'h308;
        flush    = 1'b1;
        step();
        check_eq("fl_acc_drop", out_valid, 0);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check_eq("fl_acc_gone", out_valid, 0);
        push(32'h0070_0193, 32'h30C);
        check_eq("fl_recover", {out_valid, out_rd, out_imm}, {1'b1, 5'd3, 32'd7});

        // Reset in the middle of a stall wipes everything.
        out_ready = 1'b0;
        push(32'h0050_0093, 32'h400);
        push(32'h0060_0113, 32'h404);
        rst      = 1'b1;
        in_inst  = 32'h0070_0193;
        in_valid = 1'b1;
        step();
        check_eq("rst2_valid", out_valid, 0);
        check_eq("rst2_fields", {out_pc, out_imm, out_rd, alu_op}, 0);
        check_eq("rst2_ctrl", ctrl(), 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        check_eq("rst2_ready", in_ready, 1);
        check_eq("rst2_idle", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
